// File: rtl/count_capture_fifo.sv
// Snapshots the upstream counter value on a capture strobe or counter wrap and
// buffers the snapshots in a first-word-fall-through FIFO with drop accounting.
module count_capture_fifo #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned ADDR_W          = 3,
    parameter bit          CAPTURE_ON_WRAP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              capture,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic              wrap_seen,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [7:0]        drop_count
);

    localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  count_prev;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wrap_evt;
    logic              push_req;
    logic              pop;
    logic              accept;
    logic              drop;

    // A wrap is strictly all-ones followed by zero; any other decrease is ignored.
    assign wrap_evt  = (count_prev == '1) && (count_in == '0);
    assign push_req  = capture || (CAPTURE_ON_WRAP && wrap_evt);
    assign out_valid = (level != '0);
    assign pop       = out_valid && out_ready;
    assign accept    = push_req && ((level != LEVEL_FULL) || pop);
    assign drop      = push_req && !accept;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            mem[wr_ptr] <= count_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_prev <= '0;
            wrap_seen  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            count_prev <= count_in;
            wrap_seen  <= wrap_evt;
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (accept && !pop) begin
                level <= level + LEVEL_ONE;
            end else if (pop && !accept) begin
                level <= level - LEVEL_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_count_capture_fifo.sv
// Scoreboard bench for count_capture_fifo: a reference model queues expected
// snapshots as stimulus is driven and retires them as the DUT hands them out.
module tb_count_capture_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] count_in;
    logic       capture;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       wrap_seen;
    logic [3:0] level;
    logic       overflow;
    logic [7:0] drop_count;

    count_capture_fifo #(
        .WIDTH(8),
        .DEPTH(8),
        .ADDR_W(3),
        .CAPTURE_ON_WRAP(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .count_in(count_in),
        .capture(capture),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .wrap_seen(wrap_seen),
        .level(level),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0] exp_q [$];
    logic [7:0] m_prev;
    logic       m_wrap_seen;
    logic       m_overflow;
    int unsigned m_drops;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_prev      = 8'h00;
        m_wrap_seen = 1'b0;
        m_overflow  = 1'b0;
        m_drops     = 0;
    endtask

    // Called just after a falling edge: drive inputs, check registered outputs,
    // then advance the model across the coming rising edge.
    task automatic cycle(input logic cap, input logic [7:0] cnt, input logic rdy);
        logic       wrap;
        logic       push;
        logic       pop;
        logic       full;
        logic [7:0] head;
        capture   = cap;
        count_in  = cnt;
        out_ready = rdy;
        head = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("out_data", 32'(out_data), 32'(head));
        check("level", 32'(level), exp_q.size());
        check("wrap_seen", 32'(wrap_seen), 32'(m_wrap_seen));
        check("overflow", 32'(overflow), 32'(m_overflow));
        check("drop_count", 32'(drop_count), m_drops);
        wrap = (m_prev == 8'hFF) && (cnt == 8'h00);
        push = cap || wrap;
        full = (exp_q.size() == 8);
        pop  = (exp_q.size() != 0) && rdy;
        if (pop) begin
            void'(exp_q.pop_front());
        end
        if (push) begin
            if (!full || pop) begin
                exp_q.push_back(cnt);
            end else begin
                m_overflow = 1'b1;
                if (m_drops < 255) m_drops++;
            end
        end
        m_wrap_seen = wrap;
        m_prev      = cnt;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic cap, input logic [7:0] cnt);
        reset     = 1'b1;
        capture   = cap;
        count_in  = cnt;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset     = 1'b1;
        capture   = 1'b0;
        count_in  = 8'h00;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset(1'b1, 8'h99);

        // Counter running with no capture: nothing buffered, no wrap.
        for (int i = 0; i <= 8'h20; i++) cycle(1'b0, 8'(i), 1'b0);

        // Single capture, held unread, then consumed.
        cycle(1'b1, 8'h11, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'(8'h12 + i), 1'b0);
        cycle(1'b0, 8'h17, 1'b1);
        cycle(1'b0, 8'h18, 1'b0);

        // Wrap with capture low, then with capture high in the wrap cycle.
        for (int rep = 0; rep < 2; rep++) begin
            cycle(1'b0, 8'hFE, 1'b0);
            cycle(1'b0, 8'hFF, 1'b0);
            cycle(rep == 1, 8'h00, 1'b0);
            cycle(1'b0, 8'h01, 1'b0);
            cycle(1'b0, 8'h02, 1'b1);
            cycle(1'b0, 8'h03, 1'b0);
        end

        // Decreases that are not wraps.
        cycle(1'b0, 8'h80, 1'b0);
        cycle(1'b0, 8'h05, 1'b0);
        cycle(1'b0, 8'hFE, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'hFF, 1'b0);
        cycle(1'b0, 8'h01, 1'b0);

        // Level-1 push and pop together: head replaced, valid stays high.
        cycle(1'b1, 8'h40, 1'b0);
        cycle(1'b1, 8'h41, 1'b1);
        cycle(1'b0, 8'h42, 1'b0);
        cycle(1'b0, 8'h43, 1'b1);
        cycle(1'b0, 8'h44, 1'b0);

        // Overfill by two, push into a full FIFO while popping, then drain.
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
        cycle(1'b0, 8'h3A, 1'b0);
        cycle(1'b1, 8'h50, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'(8'h51 + i), 1'b1);

        // Five buffered entries with overflow set, then reset with a capture.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        do_reset(1'b1, 8'h70);
        cycle(1'b0, 8'h71, 1'b0);
        cycle(1'b0, 8'h72, 1'b0);

        // Drop counter saturation.
        for (int i = 0; i < 8 + 260; i++) cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, 8'h10, 1'b1);
        cycle(1'b0, 8'h10, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
